// File: rtl/uart_rx_fifo.sv
// UART receive front end: two-flop line synchroniser, 16x oversampled 8N1
// frame recovery, and a small first-word-fall-through FIFO of received bytes.
//
//   state | meaning
//   IDLE  | line idle, waiting for a fresh 1->0 edge
//   START | counting to mid start bit to reject glitches
//   DATA  | sampling DATA_BITS data bits, LSB first, once per bit
//   STOP  | counting to mid stop bit, then write byte or flag an error
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 651,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                 clock,
    input  logic                 resetGral,
    input  logic                 uartRxPin,
    input  logic                 rdEn,
    input  logic                 clrErr,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxEmpty,
    output logic                 rxFull,
    output logic                 frameErr,
    output logic                 overrun
);

    localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BC_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(BAUD_DIV - 1);
    localparam logic [BC_W-1:0]   BC_LAST    = BC_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                 rxMeta;
    logic                 rxS;
    logic                 rxPrev;
    logic                 fallEdge;

    logic [TICK_W-1:0]    tickCnt;
    logic                 tick;

    logic [1:0]           state;
    logic [3:0]           sc;
    logic [BC_W-1:0]      bc;
    logic [DATA_BITS-1:0] shiftReg;

    logic                 stopSample;
    logic                 wrReq;
    logic                 wrEn;
    logic                 rdDo;
    logic                 setOverrun;
    logic                 setFrameErr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wrPtr;
    logic [ADDR_W-1:0]    rdPtr;
    logic [CNT_W-1:0]     count;

    assign fallEdge = rxPrev & ~rxS;
    assign tick     = (tickCnt == TICK_LAST);

    // A completed frame is resolved on the mid stop-bit tick.
    assign stopSample  = (state == STOP) && tick && (sc == 4'd15);
    assign wrReq       = stopSample && rxS;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wrEn        = wrReq && (!rxFull || rdEn);
    assign rdDo        = rdEn && !rxEmpty;
    assign setOverrun  = wrReq && rxFull && !rdEn;
    assign setFrameErr = stopSample && !rxS;

    assign rxData  = mem[rdPtr];
    assign rxEmpty = (count == '0);
    assign rxFull  = (count == COUNT_FULL);

    // Two-flop synchroniser plus one-cycle history for edge detection.
    always_ff @(posedge clock) begin
        if (resetGral) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= uartRxPin;
            rxS    <= rxMeta;
            rxPrev <= rxS;
        end
    end

    // Oversample tick; restarted on the start edge so the sample phase is fixed.
    always_ff @(posedge clock) begin
        if (resetGral || (state == IDLE && fallEdge)) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + TICK_W'(1);
        end
    end

    // Frame recovery FSM; advances on ticks except for the idle edge detect.
    always_ff @(posedge clock) begin
        if (resetGral) begin
            state    <= IDLE;
            sc       <= 4'd0;
            bc       <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fallEdge) begin
                        state <= START;
                        sc    <= 4'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sc == 4'd7) begin
                            sc <= 4'd0;
                            bc <= '0;
                            if (!rxS) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sc == 4'd15) begin
                            sc       <= 4'd0;
                            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
                            if (bc == BC_LAST) begin
                                state <= STOP;
                            end else begin
                                bc <= bc + BC_W'(1);
                            end
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sc == 4'd15) begin
                            sc    <= 4'd0;
                            state <= IDLE;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (resetGral) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= shiftReg;
                wrPtr      <= wrPtr + ADDR_W'(1);
            end
            if (rdDo) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({wrEn, rdDo})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (resetGral) begin
            frameErr <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (setFrameErr) begin
                frameErr <= 1'b1;
            end else if (clrErr) begin
                frameErr <= 1'b0;
            end
            if (setOverrun) begin
                overrun <= 1'b1;
            end else if (clrErr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front end for the debug unit. It synchronises the serial line, recovers 8N1 frames using a 16x oversampling baud tick, and buffers received bytes in a small first-word-fall-through FIFO. The debug control FSM pops command bytes ('s', 'n', 'c', ...) from this FIFO through a read-enable handshake.

Parameters:
BAUD_DIV, 651, clocks per 16x oversample tick (651 x 16 = 10416 clocks per bit)
DATA_BITS, 8, data bits per frame, LSB first
FIFO_DEPTH, 4, FIFO entries; must be a power of 2
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clock  input  1  system clock; all logic on rising edge
resetGral  input  1  synchronous, active-high reset
uartRxPin  input  1  asynchronous serial line, idle high
rdEn  input  1  pop head entry; ignored when rxEmpty=1
clrErr  input  1  clears frameErr and overrun
rxData  output  DATA_BITS  FIFO head byte; valid only while rxEmpty=0
rxEmpty  output  1  FIFO holds 0 entries
rxFull  output  1  FIFO holds FIFO_DEPTH entries
frameErr  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: complete frame arrived while the FIFO was full

Behaviour:
- Reset: rxData=0, rxEmpty=1, rxFull=0, frameErr=0, overrun=0. FSM=IDLE, pointers and count=0, synchroniser flops=1, tick counter=0.
- Synchroniser: two flops on uartRxPin, giving rxS. rxPrev holds the previous rxS. The falling edge is rxPrev=1 and rxS=0.
- Tick generator: counter 0..BAUD_DIV-1. It pulses tick for 1 cycle when count=BAUD_DIV-1, then wraps to 0. It is forced to 0 on the falling-edge cycle in IDLE, so sample phase is deterministic.
- The FSM uses sample counter sc (4 bits) and bit counter bc (3 bits). It advances only on tick cycles, except for the IDLE edge detect.
  - IDLE: on falling edge, go to START with sc=0. A line that is held low does not re-arm; a new 1->0 edge is required.
  - START: on the 8th tick (mid start bit), if rxS=0 go to DATA with sc=0, bc=0. Otherwise treat it as a glitch and return to IDLE with no flags set.
  - DATA: on every 16th tick, shift rxS into the shift register MSB and shift right, so the LSB arrives first. bc increments. After the DATA_BITS-th sample, go to STOP with sc=0.
  - STOP: on the 16th tick (mid stop bit):
    - rxS=1 and FIFO not full (or rdEn in the same cycle): write the byte.
    - rxS=1 and FIFO full without rdEn: discard the byte and set overrun=1.
    - rxS=0: discard the byte and set frameErr=1.
    - In all cases return to IDLE.
- Latency: the byte is written at the STOP mid-sample edge. rxEmpty falls and rxData is valid on the next cycle. Nominal time from the pin's falling edge is 2 + 9.5 x 10416 = 98954 clocks; the bench must accept a tolerance of ±3 clocks.
- FIFO:
  - Write pointer, read pointer, and a count register (0..FIFO_DEPTH).
  - rxData = mem[rdPtr], combinational from registered state.
  - rdEn with rxEmpty=0 advances rdPtr on the edge.
  - Simultaneous write and read leaves count unchanged; this is also legal when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - rxEmpty = (count==0) and rxFull = (count==FIFO_DEPTH), both registered-state derived.
- Flags: frameErr and overrun are sticky until clrErr=1. If clrErr and a new error occur in the same cycle, the set wins.
- Reset mid-frame: everything returns to reset values on the next edge. A partial frame is discarded, and the FIFO is emptied.
- No output is driven X after reset; rxData holds its last head value when empty.

Test Plan:
1. Reset, then idle line for 1000 clocks -> rxEmpty=1, rxFull=0, frameErr=0, overrun=0, rxData=0x00, FSM stays IDLE.
2. Send 0x73 ('s') at 10416 clocks/bit starting at t0 -> rxEmpty=0 at t0+98954±3 and rxData=0x73. Pulse rdEn for 1 cycle -> rxEmpty=1 next cycle.
3. Send 0x6E ('n') then 0x63 ('c') back to back with no reads -> count=2, rxData=0x6E. After 1 rdEn, rxData=0x63. After a 2nd rdEn, rxEmpty=1. A 3rd rdEn while empty changes nothing.
4. Drive the line low for 3000 clocks then high (glitch) -> no write, no flags, FSM back in IDLE. A following 0x73 frame is received correctly.
5. Send 0x55 with the stop bit forced 0 -> frameErr=1, rxEmpty stays 1. The line is held low afterwards and no new frame starts until a fresh edge. clrErr pulse -> frameErr=0.
6. Send 5 bytes (0x01..0x05) with no reads -> rxFull=1 after the 4th, overrun=1 after the 5th, and popping yields 0x01..0x04 only. Repeat with resetGral asserted mid-way through byte 3 -> FIFO empty, flags clear, and the next full frame 0x63 is received correctly.
